round_controller: RTL and testbench
===================================

# round_controller

Sequences one game of black-and-white between two players holding cards 0–8 (even = black, odd = white). It accepts card plays turn by turn, validates them against each player's remaining-card mask, resolves each round and keeps score. It ends the game after 9 rounds or as soon as the result is mathematically decided. Its two 9-bit hand masks drive the black/white counters, which display each player's remaining black and white cards.

## Interface
- No parameters. Card count (9), round count (9) and widths are fixed by the game.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a new game; honoured only in IDLE or DONE.
- sel_valid  in  1  current player presents a card.
- sel_card  in  4  card number presented, legal values 0–8.
- sel_ready  out  1  high in FIRST and SECOND.
- sel_err  out  1  one-cycle pulse when a presented card is rejected.
- turn  out  1  player who must play now: 0 = P1, 1 = P2.
- p1_card  out  9  P1 remaining-card mask; bit n = card n still held.
- p2_card  out  9  P2 remaining-card mask; same encoding.
- shown_valid  out  1  high in SECOND.
- shown_color  out  1  color of the first card of the round: 1 = white (odd), 0 = black. Meaningful only while shown_valid.
- p1_score  out  4  rounds won by P1.
- p2_score  out  4  rounds won by P2.
- round  out  4  current round number 1–9; 0 in IDLE after reset.
- result_valid  out  1  one-cycle pulse when a round resolves.
- round_winner  out  2  00 = tie, 01 = P1, 10 = P2; held until the next resolve.
- game_over  out  1  high in DONE.
- winner  out  2  final result, same encoding as round_winner; valid while game_over.

## Operation
- States: IDLE, FIRST, SECOND, RESOLVE, DONE.
- Reset values: state IDLE; both masks 9'h1FF; scores 0; round 0; turn 0; round_winner 00; winner 00. All pulses and flags are low.
- IDLE or DONE with start = 1:
  - masks go to 9'h1FF, scores to 0, round to 1, turn to 0.
  - state goes to FIRST.
- start in FIRST, SECOND or RESOLVE is ignored.
- Accept condition: sel_valid & sel_ready & sel_card ≤ 8 & the bit for sel_card is set in the mask of the player given by turn.
- Reject condition: sel_valid & sel_ready and either sel_card > 8 or the card's bit is already clear.
  - sel_err pulses.
  - No state, mask or turn change.
- FIRST, on accept:
  - register the card as first_card and the current turn as leader.
  - clear the card's bit in that player's mask.
  - invert turn and go to SECOND.
- SECOND, on accept:
  - register the card as second_card.
  - clear its bit in that player's mask.
  - go to RESOLVE.
- RESOLVE (exactly one cycle):
  - Higher card wins the round; the winner's score increments.
  - Equal cards are a tie; no score change.
  - round_winner updates and result_valid pulses.
  - Next leader: the round winner; on a tie, the leader stays the same. turn is set to the next leader.
  - Decided test uses the updated scores: |p1_score − p2_score| > 9 − round, or round = 9.
  - If decided: winner = leading player (00 if scores equal) and state goes to DONE. round is not incremented.
  - Otherwise: round increments and state goes to FIRST.
- DONE: masks, scores and round hold until start or reset.
- Arithmetic: scores and round are 4-bit unsigned. Scores never exceed 9 and round never exceeds 9, so no wrap is possible.
- reset in any state (including mid-round) overrides everything and returns all outputs to their reset values.

## Timing
- Masks, turn, shown_valid and shown_color update on the edge that samples the accept, so they are visible the next cycle.
- sel_err is registered: it is high the cycle after the rejected presentation.
- Second accept at edge N:
  - RESOLVE during cycle N+1.
  - Scores, round_winner and result_valid visible from N+2.
  - FIRST (sel_ready high) or DONE from N+2.
- sel_ready is low during RESOLVE; sel_valid there is ignored, with no sel_err.
- Minimum round length: 3 cycles.

## Test plan
- Reset, then start:
  - After reset: p1_card = p2_card = 1FF, scores 0, round 0, game_over 0, sel_ready 0.
  - After start: round = 1, turn = 0, sel_ready = 1.
- Round 1, P1 plays 8, P2 plays 0:
  - After P1's play: shown_color = 0.
  - After resolve: p1_card = 0FF, p2_card = 1FE, round_winner = 01, p1_score = 1, turn = 0, round = 2.
- Rejected plays, continuing from the previous scenario:
  - P1 presents 8 → sel_err pulse, p1_card remains 0FF, still in FIRST.
  - P1 presents 9 → sel_err pulse, no state change.
- Tie round: P1 plays 3, P2 plays 3.
  - shown_color = 1 while in SECOND.
  - round_winner = 00, scores unchanged, turn unchanged.
- Early termination:
  - Plays (P1, P2): (8, 7), (7, 6), (6, 5), (5, 4), (4, 3).
  - After round 5: p1_score = 5, game_over = 1, winner = 01, round = 5.
  - Further sel_valid is ignored; start restarts with both masks at 1FF.
- Full game with P2 winning the last round and final score 4–4 with one tie:
  - game_over after round 9, winner = 00.
  - Separately: reset asserted while in SECOND → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/round_controller.sv
// Purpose: sequences one nine-round black-and-white game between two players holding cards 0-8.
// Latency: card accept is visible the next cycle; a round resolves one cycle after the second accept.
// Backpressure: sel_ready is high only in FIRST/SECOND; sel_valid is ignored elsewhere and never errors there.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start               - begin a new game (honoured in IDLE or DONE only)
//   sel_valid/sel_card  - current player presents card sel_card (legal 0-8)
//   sel_ready           - presentation can be taken this cycle
//   sel_err             - registered one-cycle pulse for a rejected presentation
//   turn                - player to play now (0 = P1, 1 = P2)
//   p1_card/p2_card     - remaining-card masks, bit n = card n still held
//   shown_valid/color   - first card of the round is showing; its colour (1 = white/odd)
//   p1_score/p2_score   - rounds won
//   round               - current round 1-9 (0 after reset)
//   result_valid        - one-cycle pulse when a round resolves
//   round_winner        - 00 tie, 01 P1, 10 P2; held until the next resolve
//   game_over/winner    - game finished and final result (same encoding)
module round_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sel_valid,
    input  logic [3:0] sel_card,
    output logic       sel_ready,
    output logic       sel_err,
    output logic       turn,
    output logic [8:0] p1_card,
    output logic [8:0] p2_card,
    output logic       shown_valid,
    output logic       shown_color,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] round,
    output logic       result_valid,
    output logic [1:0] round_winner,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRST   = 3'd1,
        SECOND  = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [8:0] FULL_HAND = 9'h1FF;
    localparam logic [3:0] LAST_CARD = 4'd8;
    localparam logic [3:0] LAST_ROUND = 4'd9;

    localparam logic [1:0] RES_TIE = 2'b00;
    localparam logic [1:0] RES_P1  = 2'b01;
    localparam logic [1:0] RES_P2  = 2'b10;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t     state, state_nxt;
    logic [8:0] p1_card_nxt, p2_card_nxt;
    logic [3:0] p1_score_nxt, p2_score_nxt;
    logic [3:0] round_nxt;
    logic       turn_nxt;
    logic       leader, leader_nxt;
    logic [3:0] first_card, first_card_nxt;
    logic [3:0] second_card, second_card_nxt;
    logic       sel_err_nxt;
    logic       result_valid_nxt;
    logic [1:0] round_winner_nxt;
    logic [1:0] winner_nxt;

    // ------------------------------------------------------------------
    // Card validation
    // ------------------------------------------------------------------
    logic [8:0] card_bit;
    logic [8:0] turn_mask;
    logic       card_ok;
    logic       accept;
    logic       reject;

    // Shifting a one by 9..15 falls off the 9-bit vector, so out-of-range
    // cards naturally find no held bit; the explicit range check is kept
    // so the intent is obvious.
    assign card_bit  = 9'd1 << sel_card;
    assign turn_mask = turn ? p2_card : p1_card;
    assign card_ok   = (sel_card <= LAST_CARD) && ((card_bit & turn_mask) != 9'd0);
    assign accept    = sel_valid && sel_ready && card_ok;
    assign reject    = sel_valid && sel_ready && !card_ok;

    // ------------------------------------------------------------------
    // Round resolution
    // ------------------------------------------------------------------
    logic [3:0] p1_val, p2_val;
    logic       p1_wins, p2_wins;
    logic [3:0] p1_score_upd, p2_score_upd;
    logic [3:0] score_diff;
    logic [3:0] rounds_left;
    logic       decided;

    // The leader played first_card; the follower played second_card.
    assign p1_val  = leader ? second_card : first_card;
    assign p2_val  = leader ? first_card  : second_card;
    assign p1_wins = p1_val > p2_val;
    assign p2_wins = p2_val > p1_val;

    assign p1_score_upd = p1_score + {3'd0, p1_wins};
    assign p2_score_upd = p2_score + {3'd0, p2_wins};
    assign score_diff   = (p1_score_upd >= p2_score_upd) ? (p1_score_upd - p2_score_upd)
                                                         : (p2_score_upd - p1_score_upd);
    // round is 1..9 whenever RESOLVE is reached, so this never underflows.
    assign rounds_left  = LAST_ROUND - round;
    // The trailing player cannot catch up once the gap exceeds the rounds left.
    assign decided      = (score_diff > rounds_left) || (round == LAST_ROUND);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt        = state;
        p1_card_nxt      = p1_card;
        p2_card_nxt      = p2_card;
        p1_score_nxt     = p1_score;
        p2_score_nxt     = p2_score;
        round_nxt        = round;
        turn_nxt         = turn;
        leader_nxt       = leader;
        first_card_nxt   = first_card;
        second_card_nxt  = second_card;
        sel_err_nxt      = reject;
        result_valid_nxt = 1'b0;
        round_winner_nxt = round_winner;
        winner_nxt       = winner;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    p1_card_nxt  = FULL_HAND;
                    p2_card_nxt  = FULL_HAND;
                    p1_score_nxt = 4'd0;
                    p2_score_nxt = 4'd0;
                    round_nxt    = 4'd1;
                    turn_nxt     = 1'b0;
                    leader_nxt   = 1'b0;
                    winner_nxt   = RES_TIE;
                    state_nxt    = FIRST;
                end
            end

            FIRST: begin
                if (accept) begin
                    first_card_nxt = sel_card;
                    leader_nxt     = turn;
                    if (turn) p2_card_nxt = p2_card & ~card_bit;
                    else      p1_card_nxt = p1_card & ~card_bit;
                    turn_nxt       = ~turn;
                    state_nxt      = SECOND;
                end
            end

            SECOND: begin
                if (accept) begin
                    second_card_nxt = sel_card;
                    if (turn) p2_card_nxt = p2_card & ~card_bit;
                    else      p1_card_nxt = p1_card & ~card_bit;
                    state_nxt       = RESOLVE;
                end
            end

            RESOLVE: begin
                p1_score_nxt     = p1_score_upd;
                p2_score_nxt     = p2_score_upd;
                result_valid_nxt = 1'b1;
                if (p1_wins) begin
                    round_winner_nxt = RES_P1;
                    leader_nxt       = 1'b0;
                end else if (p2_wins) begin
                    round_winner_nxt = RES_P2;
                    leader_nxt       = 1'b1;
                end else begin
                    round_winner_nxt = RES_TIE;
                    leader_nxt       = leader;
                end
                turn_nxt = leader_nxt;

                if (decided) begin
                    if (p1_score_upd > p2_score_upd)      winner_nxt = RES_P1;
                    else if (p2_score_upd > p1_score_upd) winner_nxt = RES_P2;
                    else                                  winner_nxt = RES_TIE;
                    state_nxt = DONE;
                end else begin
                    round_nxt = round + 4'd1;
                    state_nxt = FIRST;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            p1_card      <= FULL_HAND;
            p2_card      <= FULL_HAND;
            p1_score     <= 4'd0;
            p2_score     <= 4'd0;
            round        <= 4'd0;
            turn         <= 1'b0;
            leader       <= 1'b0;
            first_card   <= 4'd0;
            second_card  <= 4'd0;
            sel_err      <= 1'b0;
            result_valid <= 1'b0;
            round_winner <= RES_TIE;
            winner       <= RES_TIE;
        end else begin
            state        <= state_nxt;
            p1_card      <= p1_card_nxt;
            p2_card      <= p2_card_nxt;
            p1_score     <= p1_score_nxt;
            p2_score     <= p2_score_nxt;
            round        <= round_nxt;
            turn         <= turn_nxt;
            leader       <= leader_nxt;
            first_card   <= first_card_nxt;
            second_card  <= second_card_nxt;
            sel_err      <= sel_err_nxt;
            result_valid <= result_valid_nxt;
            round_winner <= round_winner_nxt;
            winner       <= winner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    assign sel_ready   = (state == FIRST) || (state == SECOND);
    assign shown_valid = (state == SECOND);
    assign shown_color = first_card[0];
    assign game_over   = (state == DONE);

endmodule

// File: tb/tb_round_controller.sv
// Purpose: directed self-checking bench for round_controller.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: plays are only presented while the bench expects sel_ready.
module tb_round_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sel_valid;
    logic [3:0] sel_card;
    logic       sel_ready;
    logic       sel_err;
    logic       turn;
    logic [8:0] p1_card;
    logic [8:0] p2_card;
    logic       shown_valid;
    logic       shown_color;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] round;
    logic       result_valid;
    logic [1:0] round_winner;
    logic       game_over;
    logic [1:0] winner;

    int vectors    = 0;
    int miscompares = 0;

    round_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sel_valid    (sel_valid),
        .sel_card     (sel_card),
        .sel_ready    (sel_ready),
        .sel_err      (sel_err),
        .turn         (turn),
        .p1_card      (p1_card),
        .p2_card      (p2_card),
        .shown_valid  (shown_valid),
        .shown_color  (shown_color),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .round        (round),
        .result_valid (result_valid),
        .round_winner (round_winner),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one card for one cycle; returns on the falling edge after the sampling edge.
    task automatic present(input logic [3:0] c);
        sel_valid = 1'b1;
        sel_card  = c;
        @(negedge clk);
        sel_valid = 1'b0;
        sel_card  = 4'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full-game table: leader card, follower card, expected result after resolve.
    int fa   [9] = '{8, 0, 1, 1, 2, 2, 3, 4, 3};
    int fb   [9] = '{0, 8, 7, 7, 6, 6, 5, 4, 5};
    int e_rw [9] = '{1, 2, 1, 2, 1, 2, 1, 0, 2};
    int e_p1 [9] = '{1, 1, 2, 2, 3, 3, 4, 4, 4};
    int e_p2 [9] = '{0, 1, 1, 2, 2, 3, 3, 3, 4};
    int e_tn [9] = '{0, 1, 0, 1, 0, 1, 0, 0, 1};

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        sel_valid = 1'b0;
        sel_card  = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values
        check("rst_p1_card",   16'(p1_card),   16'h1FF);
        check("rst_p2_card",   16'(p2_card),   16'h1FF);
        check("rst_p1_score",  16'(p1_score),  16'h0);
        check("rst_p2_score",  16'(p2_score),  16'h0);
        check("rst_round",     16'(round),     16'h0);
        check("rst_game_over", 16'(game_over), 16'h0);
        check("rst_sel_ready", 16'(sel_ready), 16'h0);
        check("rst_turn",      16'(turn),      16'h0);

        // Start
        pulse_start();
        check("start_round",     16'(round),     16'h1);
        check("start_turn",      16'(turn),      16'h0);
        check("start_sel_ready", 16'(sel_ready), 16'h1);

        // Round 1: P1 plays 8, P2 plays 0
        present(4'd8);
        check("r1_shown_valid", 16'(shown_valid), 16'h1);
        check("r1_shown_color", 16'(shown_color), 16'h0);
        check("r1_turn_p2",     16'(turn),        16'h1);
        check("r1_p1_card",     16'(p1_card),     16'h0FF);
        present(4'd0);
        check("r1_resolve_rdy", 16'(sel_ready),   16'h0);
        check("r1_p2_card",     16'(p2_card),     16'h1FE);
        @(negedge clk);
        check("r1_result_valid", 16'(result_valid), 16'h1);
        check("r1_round_winner", 16'(round_winner), 16'h1);
        check("r1_p1_score",     16'(p1_score),     16'h1);
        check("r1_p2_score",     16'(p2_score),     16'h0);
        check("r1_turn",         16'(turn),         16'h0);
        check("r1_round",        16'(round),        16'h2);
        check("r1_sel_ready",    16'(sel_ready),    16'h1);

        // Rejects: P1 re-presents 8, then 9
        present(4'd8);
        check("rej8_sel_err",      16'(sel_err),      16'h1);
        check("rej8_result_pulse", 16'(result_valid), 16'h0);
        check("rej8_p1_card",      16'(p1_card),      16'h0FF);
        check("rej8_shown_valid",  16'(shown_valid),  16'h0);
        check("rej8_turn",         16'(turn),         16'h0);
        present(4'd9);
        check("rej9_sel_err",     16'(sel_err),     16'h1);
        check("rej9_shown_valid", 16'(shown_valid), 16'h0);
        check("rej9_p1_card",     16'(p1_card),     16'h0FF);
        check("rej9_sel_ready",   16'(sel_ready),   16'h1);
        @(negedge clk);
        check("rej_err_clears",   16'(sel_err),     16'h0);

        // Tie round: 3 vs 3
        present(4'd3);
        check("tie_shown_color", 16'(shown_color), 16'h1);
        check("tie_p1_card",     16'(p1_card),     16'h0F7);
        present(4'd3);
        @(negedge clk);
        check("tie_round_winner", 16'(round_winner), 16'h0);
        check("tie_p1_score",     16'(p1_score),     16'h1);
        check("tie_p2_score",     16'(p2_score),     16'h0);
        check("tie_turn",         16'(turn),         16'h0);
        check("tie_round",        16'(round),        16'h3);
        check("tie_p2_card",      16'(p2_card),      16'h1F6);

        // Start is ignored mid-game
        pulse_start();
        check("ign_start_round",   16'(round),   16'h3);
        check("ign_start_p1_card", 16'(p1_card), 16'h0F7);

        // Reset while in SECOND
        present(4'd2);
        check("mid_shown_valid", 16'(shown_valid), 16'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_p1_card",     16'(p1_card),      16'h1FF);
        check("mid_rst_p2_card",     16'(p2_card),      16'h1FF);
        check("mid_rst_p1_score",    16'(p1_score),     16'h0);
        check("mid_rst_round",       16'(round),        16'h0);
        check("mid_rst_shown_valid", 16'(shown_valid),  16'h0);
        check("mid_rst_sel_ready",   16'(sel_ready),    16'h0);
        check("mid_rst_turn",        16'(turn),         16'h0);
        check("mid_rst_game_over",   16'(game_over),    16'h0);

        // Early termination: P1 wins five straight
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            present(4'(8 - i));
            present(4'(7 - i));
            @(negedge clk);
            check("early_p1_score", 16'(p1_score), 16'(i + 1));
            if (i == 3) begin
                check("early_r4_game_over", 16'(game_over), 16'h0);
                check("early_r4_round",     16'(round),     16'h5);
            end
        end
        check("early_game_over", 16'(game_over), 16'h1);
        check("early_winner",    16'(winner),    16'h1);
        check("early_round",     16'(round),     16'h5);
        check("early_p2_score",  16'(p2_score),  16'h0);
        check("early_sel_ready", 16'(sel_ready), 16'h0);
        check("early_p1_card",   16'(p1_card),   16'h00F);
        check("early_p2_card",   16'(p2_card),   16'h107);

        present(4'd0);
        check("done_ignore_err",   16'(sel_err),   16'h0);
        check("done_ignore_mask",  16'(p1_card),   16'h00F);
        check("done_ignore_over",  16'(game_over), 16'h1);

        pulse_start();
        check("restart_p1_card",   16'(p1_card),   16'h1FF);
        check("restart_p2_card",   16'(p2_card),   16'h1FF);
        check("restart_round",     16'(round),     16'h1);
        check("restart_p1_score",  16'(p1_score),  16'h0);
        check("restart_game_over", 16'(game_over), 16'h0);

        // Full game ending 4-4 with one tie
        for (int i = 0; i < 9; i++) begin
            present(4'(fa[i]));
            present(4'(fb[i]));
            @(negedge clk);
            check("full_round_winner", 16'(round_winner), 16'(e_rw[i]));
            check("full_p1_score",     16'(p1_score),     16'(e_p1[i]));
            check("full_p2_score",     16'(p2_score),     16'(e_p2[i]));
            check("full_turn",         16'(turn),         16'(e_tn[i]));
            if (i == 7) begin
                check("full_r8_game_over", 16'(game_over), 16'h0);
                check("full_r8_round",     16'(round),     16'h9);
            end
        end
        check("full_game_over", 16'(game_over), 16'h1);
        check("full_winner",    16'(winner),    16'h0);
        check("full_round",     16'(round),     16'h9);
        check("full_p1_card",   16'(p1_card),   16'h000);
        check("full_p2_card",   16'(p2_card),   16'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
